// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state type and priority helpers for the PIC interrupt core
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } pic_state_e;

  // Id latched on an acknowledge that finds no unmasked request.
  function automatic logic [31:0] spurious_id(input logic [31:0] n);
    return n - 32'd1;
  endfunction

  // Returns {valid, id}; priority starts just after `lowest` and wraps at n.
  function automatic logic [5:0] rot_find_first(input logic [31:0] req,
                                                input logic [31:0] n,
                                                input logic [31:0] lowest);
    logic [5:0]  r;
    logic [31:0] s;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (32'(i) < n) begin
        s = lowest + 32'd1 + 32'(i);
        if (s >= n) s = s - n;
        if (req[s[4:0]]) r = {1'b1, s[4:0]};
      end
    end
    return r;
  endfunction

  // Position in the current priority order; 0 is the highest priority.
  function automatic logic [31:0] prio_rank(input logic [31:0] id,
                                            input logic [31:0] lowest,
                                            input logic [31:0] n);
    return (id > lowest) ? (id - lowest - 32'd1) : (id + n - lowest - 32'd1);
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// rtl/pic_prio_resolver.sv - combinational rotating-priority find-first
module pic_prio_resolver
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req_i,
  input  logic [ID_W-1:0]  lowest_prio_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  id_o
);

  logic [31:0] req_ext;
  logic [5:0]  res;

  always_comb begin
    req_ext              = '0;
    req_ext[N_IRQ-1:0]   = req_i;
    res                  = rot_find_first(req_ext, 32'(N_IRQ), 32'(lowest_prio_i));
    valid_o              = res[5];
    id_o                 = ID_W'(res[4:0]);
  end

endmodule

// File: rtl/pic_irq_core.sv
// rtl/pic_irq_core.sv - IRR/ISR/IMR priority core with INTA handshake, EOI and status reads
module pic_irq_core
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int T_W   = 5,
  parameter int ID_W  = $clog2(N_IRQ),
  localparam int VEC_W = T_W + ID_W,
  localparam int DW    = (VEC_W > N_IRQ) ? VEC_W : N_IRQ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] ir,
  input  logic             ltim,
  input  logic             aeoi,
  input  logic             rotate,
  input  logic [T_W-1:0]   t_base,
  input  logic [N_IRQ-1:0] imr,
  input  logic             inta_n,
  input  logic             eoi_valid,
  input  logic             eoi_specific,
  input  logic [ID_W-1:0]  eoi_level,
  input  logic             rd_irr,
  input  logic             rd_isr,
  output logic             int_o,
  output logic [DW-1:0]    data_o,
  output logic             data_oe,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr
);

  logic [N_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, ir_prev_q, cand;
  logic [ID_W-1:0]  lowest_q, lowest_d, id_q, id_d, win, isr_top;
  logic             win_valid, isr_valid, inta_fall;
  logic             spurious_q, spurious_d, int_q, int_d, inta_prev_q, oe_q, oe_d;
  logic [DW-1:0]    data_q, data_d;
  pic_state_e       state_q, state_d;

  assign cand      = irr_q & ~imr;
  assign inta_fall = inta_prev_q & ~inta_n;

  pic_prio_resolver #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_cand_res (
    .req_i(cand), .lowest_prio_i(lowest_q), .valid_o(win_valid), .id_o(win)
  );

  pic_prio_resolver #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_isr_res (
    .req_i(isr_q), .lowest_prio_i(lowest_q), .valid_o(isr_valid), .id_o(isr_top)
  );

  always_comb begin
    irr_d      = ltim ? ir : ((irr_q & ir) | (ir & ~ir_prev_q));
    isr_d      = isr_q;
    lowest_d   = lowest_q;
    id_d       = id_q;
    spurious_d = spurious_q;
    state_d    = state_q;
    data_d     = '0;
    oe_d       = 1'b0;
    int_d      = win_valid &&
                 (!isr_valid ||
                  (prio_rank(32'(win), 32'(lowest_q), 32'(N_IRQ)) <
                   prio_rank(32'(isr_top), 32'(lowest_q), 32'(N_IRQ))));

    // EOI lands before any same-cycle acknowledge sets its ISR bit.
    if (eoi_valid) begin
      if (eoi_specific) begin
        if ((32'(eoi_level) < 32'(N_IRQ)) && isr_q[eoi_level]) begin
          isr_d[eoi_level] = 1'b0;
          if (rotate) lowest_d = eoi_level;
        end
      end else if (isr_valid) begin
        isr_d[isr_top] = 1'b0;
        if (rotate) lowest_d = isr_top;
      end
    end

    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d = ACK1;
          int_d   = 1'b0;
          if (win_valid) begin
            id_d         = win;
            spurious_d   = 1'b0;
            isr_d[win]   = 1'b1;
            irr_d[win]   = 1'b0;
          end else begin
            id_d       = ID_W'(spurious_id(32'(N_IRQ)));
            spurious_d = 1'b1;
          end
        end else if (rd_irr) begin
          data_d[N_IRQ-1:0] = irr_q;
          oe_d              = 1'b1;
        end else if (rd_isr) begin
          data_d[N_IRQ-1:0] = isr_q;
          oe_d              = 1'b1;
        end
      end
      ACK1: if (inta_n) state_d = GAP;
      GAP: begin
        if (inta_fall) begin
          state_d = ACK2;
          if (aeoi && !spurious_q) begin
            isr_d[id_q] = 1'b0;
            if (rotate) lowest_d = id_q;
          end
        end
      end
      ACK2: if (inta_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == ACK2) begin
      data_d[VEC_W-1:0] = {t_base, id_q};
      oe_d              = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr_q       <= '0;
      isr_q       <= '0;
      ir_prev_q   <= '0;
      lowest_q    <= ID_W'(N_IRQ - 1);
      id_q        <= '0;
      spurious_q  <= 1'b0;
      int_q       <= 1'b0;
      inta_prev_q <= 1'b0;
      oe_q        <= 1'b0;
      data_q      <= '0;
      state_q     <= IDLE;
    end else begin
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      ir_prev_q   <= ir;
      lowest_q    <= lowest_d;
      id_q        <= id_d;
      spurious_q  <= spurious_d;
      int_q       <= int_d;
      inta_prev_q <= inta_n;
      oe_q        <= oe_d;
      data_q      <= data_d;
      state_q     <= state_d;
    end
  end

  assign int_o   = int_q;
  assign data_o  = data_q;
  assign data_oe = oe_q;
  assign irr     = irr_q;
  assign isr     = isr_q;

endmodule

// File: tb/tb_pic_irq_core.sv
// tb/tb_pic_irq_core.sv - directed self-checking bench for pic_irq_core
module tb_pic_irq_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir;
  logic       ltim, aeoi, rotate;
  logic [4:0] t_base;
  logic [7:0] imr;
  logic       inta_n;
  logic       eoi_valid, eoi_specific;
  logic [2:0] eoi_level;
  logic       rd_irr, rd_isr;
  logic       int_o;
  logic [7:0] data_o;
  logic       data_oe;
  logic [7:0] irr, isr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pic_irq_core #(.N_IRQ(8), .T_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .aeoi(aeoi), .rotate(rotate),
    .t_base(t_base), .imr(imr), .inta_n(inta_n), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .rd_irr(rd_irr),
    .rd_isr(rd_isr), .int_o(int_o), .data_o(data_o), .data_oe(data_oe),
    .irr(irr), .isr(isr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic inta(input logic v);
    inta_n = v;
    step();
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    step();
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
  endtask

  task automatic do_reset();
    ir = '0; ltim = 0; aeoi = 0; rotate = 0; t_base = 5'b01110; imr = '0;
    inta_n = 1; eoi_valid = 0; eoi_specific = 0; eoi_level = '0;
    rd_irr = 0; rd_isr = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  initial begin
    do_reset();
    rst_n = 0;
    #1;
    check("rst_int", int_o, 0);
    check("rst_data", data_o, 0);
    check("rst_oe", data_oe, 0);
    check("rst_irr", irr, 0);
    check("rst_isr", isr, 0);

    // Masked low nibble, AEOI, vector 0x75
    do_reset();
    aeoi = 1; imr = 8'h0F; ir = 8'h64;
    step();
    check("t1_irr", irr, 8'h64);
    step();
    check("t1_int", int_o, 1);
    inta(0);
    check("t1_isr_p1", isr, 8'h20);
    check("t1_irr_p1", irr, 8'h44);
    check("t1_int_p1", int_o, 0);
    inta(1);
    inta(0);
    check("t1_vec", data_o, 8'h75);
    check("t1_oe", data_oe, 1);
    check("t1_isr_p2", isr, 8'h00);
    inta(1);
    check("t1_oe_drop", data_oe, 0);
    check("t1_irr_end", irr, 8'h44);

    // Nesting: IR1 preempts IR5, IR6 waits for both EOIs
    do_reset();
    ir = 8'h20;
    step(); step();
    check("t2_int5", int_o, 1);
    inta(0); inta(1); inta(0);
    check("t2_vec5", data_o, 8'h75);
    inta(1);
    check("t2_isr5", isr, 8'h20);
    ir = 8'h22;
    step(); step();
    check("t2_int1", int_o, 1);
    inta(0);
    check("t2_isr22", isr, 8'h22);
    inta(1); inta(0);
    check("t2_vec1", data_o, 8'h71);
    inta(1);
    ir = 8'h62;
    step(); step();
    check("t2_int6_blk", int_o, 0);
    eoi(0, 3'd0);
    check("t2_nseoi", isr, 8'h20);
    step();
    check("t2_int6_blk2", int_o, 0);
    eoi(1, 3'd5);
    check("t2_seoi", isr, 8'h00);
    step();
    check("t2_int6", int_o, 1);

    // Rotation on non-specific EOI: IR4 beats IR2
    do_reset();
    rotate = 1; ir = 8'h08;
    step(); step();
    inta(0);
    check("t3_isr3", isr, 8'h08);
    inta(1); inta(0);
    check("t3_vec3", data_o, 8'h73);
    inta(1);
    ir = 8'h00;
    eoi(0, 3'd0);
    check("t3_isr_clr", isr, 8'h00);
    ir = 8'h14;
    step(); step();
    check("t3_int", int_o, 1);
    inta(0);
    check("t3_isr4", isr, 8'h10);
    inta(1); inta(0);
    check("t3_vec4", data_o, 8'h74);
    inta(1);

    // Level mode: request withdrawn, spurious vector
    do_reset();
    ltim = 1; ir = 8'h08;
    step();
    check("t4_irr_lvl", irr, 8'h08);
    ir = 8'h00;
    step(); step();
    check("t4_irr0", irr, 8'h00);
    check("t4_int0", int_o, 0);
    inta(0);
    check("t4_isr_spur", isr, 8'h00);
    inta(1); inta(0);
    check("t4_vec_spur", data_o, 8'h77);
    check("t4_oe", data_oe, 1);
    inta(1);

    // Reset during GAP restores lowest_prio and handshake
    do_reset();
    aeoi = 1; rotate = 1; ir = 8'h04;
    step(); step();
    inta(0); inta(1); inta(0);
    check("t5_vec2", data_o, 8'h72);
    inta(1);
    ir = 8'h00;
    step();
    ir = 8'h09;
    step(); step();
    inta(0);
    check("t5_isr_rot", isr, 8'h08);
    inta(1);
    rst_n = 0;
    #1;
    check("t5_rst_int", int_o, 0);
    check("t5_rst_data", data_o, 0);
    check("t5_rst_oe", data_oe, 0);
    check("t5_rst_irr", irr, 0);
    check("t5_rst_isr", isr, 0);
    step();
    rst_n = 1;
    step();
    check("t5_irr", irr, 8'h09);
    step();
    inta(0);
    check("t5_isr_first", isr, 8'h01);
    check("t5_oe_first", data_oe, 0);
    inta(1);
    check("t5_oe_gap", data_oe, 0);

    // Status reads in IDLE, ignored in ACK1
    do_reset();
    ir = 8'h80;
    step(); step();
    rd_irr = 1;
    step();
    check("t6_rd_irr", data_o, 8'h80);
    check("t6_rd_oe", data_oe, 1);
    rd_isr = 1;
    step();
    check("t6_rd_both", data_o, 8'h80);
    rd_irr = 0; rd_isr = 0;
    step();
    check("t6_rd_off", data_oe, 0);
    inta(0); inta(1); inta(0);
    check("t6_vec7", data_o, 8'h77);
    inta(1);
    rd_isr = 1;
    step();
    check("t6_rd_isr", data_o, 8'h80);
    check("t6_rd_isr_oe", data_oe, 1);
    rd_isr = 0; rd_irr = 1;
    inta(0);
    check("t6_rd_fall", data_oe, 0);
    step();
    check("t6_rd_ack1", data_oe, 0);
    rd_irr = 0;
    inta(1); inta(0); inta(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pic_irq_core.md
# pic_irq_core

Parametrised, synchronous successor to the 8259A-style interrupt logic. It captures N_IRQ request lines into an IRR, masks them against IMR and ISR, and resolves priority with a rotatable fully nested scheme. It raises INT, runs the two-pulse INTA handshake and drives the vector {T, id} onto the internal bus. It also services EOI commands (specific and non-specific, with optional rotation) and status reads. It sits between the IR pins and the data-bus buffer / control logic of the PIC.

## Interface
- N_IRQ, 8: number of request lines (2..32).
- T_W, 5: width of vector base (T field).
- ID_W, $clog2(N_IRQ): request id width; vector width VEC_W = T_W+ID_W.

Clock, reset and IR/status ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ir  in  N_IRQ  request lines, already synchronised to clk.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered.
- aeoi  in  1  automatic EOI on second INTA pulse.
- rotate  in  1  rotate priority on AEOI / non-specific EOI.
- t_base  in  T_W  vector base.
- imr  in  N_IRQ  mask (1 = masked).

Handshake and EOI ports:
- inta_n  in  1  interrupt acknowledge, active low, synchronised level.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = clear eoi_level, 0 = clear highest-priority ISR bit.
- eoi_level  in  ID_W  target level for a specific EOI.
- rd_irr, rd_isr  in  1  status read requests (rd_irr wins if both are set).

Outputs:
- int_o  out  1  interrupt request to CPU.
- data_o  out  max(VEC_W,N_IRQ)  vector or status, zero-extended.
- data_oe  out  1  data_o valid.
- irr, isr  out  N_IRQ  register views.

## Operation
- Priority rotation:
  - lowest_prio register, reset value N_IRQ-1.
  - Priority order starts at (lowest_prio+1) mod N_IRQ and wraps.
- IRR in edge mode:
  - A bit sets on a 0→1 of ir[k] (previous-sample register).
  - It clears when ir[k] falls before acknowledge, or when the request is acknowledged.
- IRR in level mode: irr = ir every cycle, except an acknowledged bit is cleared that cycle.
- INT generation:
  - cand = irr & ~imr.
  - int_o = 1 when the highest-priority bit of cand has strictly higher priority than the highest-priority ISR bit, or ISR is empty.
  - The winner id is held in `win`.
- FSM states: IDLE, ACK1, GAP, ACK2.
  - IDLE→ACK1 on a falling inta_n. Latch `win`; set isr[win], clear irr[win], clear int_o. If cand is empty this is a spurious acknowledge: latch id N_IRQ-1 and leave ISR untouched.
  - ACK1→GAP on inta_n high.
  - GAP→ACK2 on a falling inta_n. Drive data_o = {t_base, id} with data_oe = 1 while inta_n stays low.
  - If aeoi: clear isr[id] on entry to ACK2. If rotate is also set, lowest_prio = id.
  - ACK2→IDLE on inta_n high. data_oe drops the same cycle.
- EOI (any state):
  - Non-specific clears the highest-priority ISR bit; if rotate, lowest_prio = that id.
  - Specific clears isr[eoi_level]; if rotate, lowest_prio = eoi_level.
  - An empty ISR or a clear bit makes EOI a no-op.
- Status read: in IDLE, rd_irr/rd_isr drive data_o = irr/isr with data_oe = 1 for each cycle the read is held. Reads are ignored outside IDLE.

## Timing
- Reset: irr = isr = 0, int_o = 0, data_o = 0, data_oe = 0, state IDLE, lowest_prio = N_IRQ-1, previous-sample ir = 0.
- Latency:
  - ir edge sampled at cycle k → irr at k+1 → int_o at k+2.
  - inta_n fall seen at cycle k → ISR/IRR updated and int_o low at k+1.
  - Second fall seen at cycle k → data_o/data_oe valid at k+1.
- Simultaneous events:
  - EOI in the same cycle as the first-INTA latch: apply EOI first, then resolve `win` and set the ISR bit.
  - A new ir edge on the acknowledged bit in the acknowledge cycle is lost.
  - Edges on other bits set normally.
- imr changes take effect on int_o one cycle later. A request that becomes masked before the first INTA yields a spurious vector.
- rst_n asserted mid-handshake returns to reset values immediately; the next inta_n fall is treated as a first pulse.

## Structure
- Package pic_pkg holds:
  - state enum {IDLE, ACK1, GAP, ACK2};
  - function for the rotating find-first;
  - SPURIOUS_ID = N_IRQ-1 helper.
- Sub-module pic_prio_resolver (combinational, N_IRQ, ID_W) takes req and lowest_prio and returns valid and id. It is instantiated twice: once for cand, once for isr.

## Test plan
- N_IRQ=8, t_base=5'b01110, imr=8'h0F, aeoi=1, ir=8'h64, two INTA pulses → int_o=1, isr[5] set after pulse 1, data_o=8'h75, isr=0 after pulse 2, irr=8'h44.
- aeoi=0, IR5 in service, raise IR1 → int_o=1, vector 8'h71, isr=8'h22. Raise IR6 → int_o stays 0 until EOIs clear IR1 and IR5.
- rotate=1, ISR[3] set, non-specific EOI, then ir=8'h14 → lowest_prio=3, vector 8'h74 (IR4 beats IR2).
- ltim=1, ir[3] pulsed high and dropped before INTA → irr=0, int_o=0. INTA pair → spurious vector 8'h77, isr unchanged.
- rst_n low during GAP → all outputs 0, lowest_prio=7. The next single INTA pulse is treated as first pulse (no vector driven).
- In IDLE: rd_irr=1 with irr=8'h80 → data_o=8'h80, data_oe=1. rd_isr=1 → data_o=isr. Reads during ACK1 → data_oe=0.
